// File: rtl/leaf_feeder_p4.sv
// Splits an incoming beat stream into sorted runs and steers each run to one of four leaf FIFOs.
// Latency: zero (data and write enable are combinational from i_data/i_valid); o_run_done lags sel advance by one cycle.
// Backpressure: o_ready drops while the selected leaf is full or a terminator is pending; full on other leaves never stalls.
// Optional LEAF_FEEDER_TERM_EN: append an all-zero terminator beat to each closed run.
module leaf_feeder_p4 #(
    parameter int DATA_WIDTH = 128,
    parameter int RUN_LEN    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [2*DATA_WIDTH-1:0]   i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_flush,
    input  logic [3:0]                i_leaf_full,
    output logic [3:0]                o_leaf_write,
    output logic [2*DATA_WIDTH-1:0]   o_leaf_data,
    output logic [1:0]                o_leaf_sel,
    output logic                      o_run_done
);

    localparam int CW = $clog2(RUN_LEN);

    typedef enum logic {
        STREAM = 1'b0,
        TERM   = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      sel;
    logic [CW-1:0]   beat_cnt;
    logic            adv_q;
    logic            run_done_q;

    logic            full_sel;
    logic            ready;
    logic            xfer;
    logic            last_beat;
    logic            flush_acc;
    logic            close_run;
    logic            term_wr;
    logic            sel_adv;
    logic            wr_en;

    always_comb begin
        full_sel  = i_leaf_full[sel];
        ready     = i_rst_n && (state == STREAM) && !full_sel;
        xfer      = ready && i_valid;
        last_beat = (beat_cnt == CW'(RUN_LEN - 1));
        // A flush only closes a run that has something in it and loses to a real transfer.
        flush_acc = i_rst_n && (state == STREAM) && i_flush && !xfer && (beat_cnt != '0);
        close_run = (xfer && last_beat) || flush_acc;
        term_wr   = 1'b0;
        state_nxt = state;
`ifdef LEAF_FEEDER_TERM_EN
        if ((state == STREAM) && close_run) begin
            state_nxt = TERM;
        end
        if ((state == TERM) && i_rst_n && !full_sel) begin
            term_wr   = 1'b1;
            state_nxt = STREAM;
        end
        sel_adv = term_wr;
`else
        sel_adv = close_run;
`endif
        wr_en = xfer || term_wr;
    end

    assign o_ready      = ready;
    assign o_leaf_write = wr_en ? (4'b0001 << sel) : 4'b0000;
    assign o_leaf_data  = xfer ? i_data : '0;
    assign o_leaf_sel   = sel;
    assign o_run_done   = run_done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= STREAM;
            sel        <= 2'd0;
            beat_cnt   <= '0;
            adv_q      <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (close_run) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (sel_adv) begin
                sel <= sel + 2'd1;
            end
            // Done pulse trails the visible sel change by one cycle.
            adv_q      <= sel_adv;
            run_done_q <= adv_q;
        end
    end

endmodule

// File: tb/tb_leaf_feeder_p4.sv
// Scoreboard bench for leaf_feeder_p4 (RUN_LEN=4); expectations follow LEAF_FEEDER_TERM_EN when defined.
module tb_leaf_feeder_p4;

    localparam int DW = 16;
    localparam int RL = 4;
    localparam int BW = 2 * DW;
`ifdef LEAF_FEEDER_TERM_EN
    localparam bit TERM_ON = 1'b1;
`else
    localparam bit TERM_ON = 1'b0;
`endif

    logic          i_clk;
    logic          i_rst_n;
    logic [BW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_flush;
    logic [3:0]    i_leaf_full;
    logic [3:0]    o_leaf_write;
    logic [BW-1:0] o_leaf_data;
    logic [1:0]    o_leaf_sel;
    logic          o_run_done;

    leaf_feeder_p4 #(.DATA_WIDTH(DW), .RUN_LEN(RL)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .i_leaf_full  (i_leaf_full),
        .o_leaf_write (o_leaf_write),
        .o_leaf_data  (o_leaf_data),
        .o_leaf_sel   (o_leaf_sel),
        .o_run_done   (o_run_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int            errors   = 0;
    int            checks   = 0;
    int            rd_total = 0;
    logic [BW-1:0] exp_q [4][$];
    logic [BW-1:0] exp_v;

    // Scoreboard: every leaf write must be legal and match the next expected beat of that leaf.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_run_done) rd_total++;
            if (o_leaf_write != 4'b0000) begin
                checks++;
                if (!$onehot(o_leaf_write) || ((o_leaf_write & i_leaf_full) != 4'b0000)) begin
                    errors++;
                    $display("FAIL leaf_write_legal write=%b full=%b", o_leaf_write, i_leaf_full);
                end
                for (int l = 0; l < 4; l++) begin
                    if (o_leaf_write[l]) begin
                        checks++;
                        if (exp_q[l].size() == 0) begin
                            errors++;
                            $display("FAIL leaf%0d_unexpected_write got=%h expected none", l, o_leaf_data);
                        end else begin
                            exp_v = exp_q[l].pop_front();
                            if (o_leaf_data !== exp_v) begin
                                errors++;
                                $display("FAIL leaf%0d_data got=%h expected=%h", l, o_leaf_data, exp_v);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_leaf_full = 4'b0000; i_data = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input int leaf);
        int n;
        i_valid = 1'b1;
        i_data  = d;
        exp_q[leaf].push_back(d);
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%b expected=1 data=%h", o_ready, d);
        end
        step();
    endtask

    task automatic send_runs(input int nbeats, input int first_val, input int start_leaf);
        int leaf;
        for (int i = 0; i < nbeats; i++) begin
            leaf = (start_leaf + i / RL) % 4;
            send_beat(BW'(first_val + i), leaf);
            if (TERM_ON && ((i % RL) == RL - 1)) exp_q[leaf].push_back('0);
        end
        i_valid = 1'b0;
    endtask

    task automatic check_drain(input string name);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (exp_q[l].size() != 0) begin
                errors++;
                $display("FAIL %s_leaf%0d_drain pending=%0d expected=0", name, l, exp_q[l].size());
                exp_q[l].delete();
            end
        end
    endtask

    task automatic check_sel(input string name, input logic [1:0] exp_sel);
        checks++;
        if (o_leaf_sel !== exp_sel) begin
            errors++;
            $display("FAIL %s_sel got=%0d expected=%0d", name, o_leaf_sel, exp_sel);
        end
    endtask

    task automatic check_done(input string name, input logic exp_d);
        checks++;
        if (o_run_done !== exp_d) begin
            errors++;
            $display("FAIL %s_run_done got=%b expected=%b", name, o_run_done, exp_d);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1; i_valid = 1'b1; i_data = '1; i_flush = 1'b1; i_leaf_full = 4'b0000;
        #2 i_rst_n = 1'b0;
        #5;
        checks++;
        if ({o_ready, o_leaf_write, o_leaf_data, o_leaf_sel, o_run_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b write=%b data=%h sel=%0d done=%b expected all 0",
                     o_ready, o_leaf_write, o_leaf_data, o_leaf_sel, o_run_done);
        end
        @(posedge i_clk);
        #1 i_rst_n = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_data = '0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b expected=1", o_ready);
        end
        check_sel("reset_release", 2'd0);
        check_done("reset_release", 1'b0);
    endtask

    task automatic test_back_to_back();
        int rd0;
        do_reset();
        rd0 = rd_total;
        send_runs(8, 1, 0);
        repeat (4) step();
        checks++;
        if (rd_total - rd0 != 2) begin
            errors++;
            $display("FAIL b2b_run_done_count got=%0d expected=2", rd_total - rd0);
        end
        check_sel("b2b", 2'd2);
        check_drain("b2b");
    endtask

    task automatic test_full_stall();
        do_reset();
        i_leaf_full = 4'b1110;
        send_beat(BW'('h11), 0);
        send_beat(BW'('h12), 0);
        send_beat(BW'('h13), 0);
`ifdef LEAF_FEEDER_TERM_EN
        send_beat(BW'('h14), 0);
        exp_q[0].push_back('0);
        i_valid = 1'b0;
        i_leaf_full = 4'b0001;
`else
        i_valid = 1'b1;
        i_data = BW'('h14);
        i_leaf_full = 4'b0001;
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_ready !== 1'b0 || o_leaf_write !== 4'b0000) begin
                errors++;
                $display("FAIL stall_cycle%0d ready=%b write=%b expected ready=0 write=0000", k, o_ready, o_leaf_write);
            end
            check_sel("stall", 2'd0);
            step();
        end
        i_leaf_full = 4'b0000;
`ifndef LEAF_FEEDER_TERM_EN
        exp_q[0].push_back(BW'('h14));
`endif
        @(negedge i_clk);
        checks++;
        if (o_leaf_write !== 4'b0001) begin
            errors++;
            $display("FAIL stall_release_write got=%b expected=0001", o_leaf_write);
        end
        step();
        i_valid = 1'b0;
        check_sel("stall_release", 2'd1);
        check_done("stall_release", 1'b0);
        step();
        check_done("stall_release_next", 1'b1);
        repeat (2) step();
        check_drain("stall");
    endtask

    task automatic test_flush();
        int rd0;
        do_reset();
        send_beat(BW'('hA), 0);
        send_beat(BW'('hB), 0);
        i_valid = 1'b0;
        if (TERM_ON) exp_q[0].push_back('0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        repeat (3) step();
        check_sel("flush_partial", 2'd1);
        send_beat(BW'('hC), 1);
        send_beat(BW'('hD), 1);
        send_beat(BW'('hE), 1);
        send_beat(BW'('hF), 1);
        i_valid = 1'b0;
        if (TERM_ON) exp_q[1].push_back('0);
        repeat (3) step();
        check_sel("flush_restart", 2'd2);
        rd0 = rd_total;
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_leaf_write !== 4'b0000) begin
            errors++;
            $display("FAIL flush_empty_write got=%b expected=0000", o_leaf_write);
        end
        step();
        i_flush = 1'b0;
        repeat (3) step();
        check_sel("flush_empty", 2'd2);
        checks++;
        if (rd_total != rd0) begin
            errors++;
            $display("FAIL flush_empty_run_done got=%0d expected=0", rd_total - rd0);
        end
        send_beat(BW'('h61), 2);
        i_flush = 1'b1;
        send_beat(BW'('h62), 2);
        i_flush = 1'b0;
        i_valid = 1'b0;
        repeat (3) step();
        check_sel("flush_with_xfer", 2'd2);
        check_drain("flush");
    endtask

    task automatic test_wrap();
        int rd0;
        do_reset();
        rd0 = rd_total;
        send_runs(16 * RL, 'h100, 0);
        repeat (4) step();
        checks++;
        if (rd_total - rd0 != 16) begin
            errors++;
            $display("FAIL wrap_run_done_count got=%0d expected=16", rd_total - rd0);
        end
        check_sel("wrap", 2'd0);
        check_drain("wrap");
    endtask

    task automatic test_run_timing();
        do_reset();
        send_beat(BW'('h31), 0);
        send_beat(BW'('h32), 0);
        send_beat(BW'('h33), 0);
        send_beat(BW'('h34), 0);
        i_valid = 1'b0;
`ifdef LEAF_FEEDER_TERM_EN
        exp_q[0].push_back('0);
        check_sel("timing_term_pending", 2'd0);
        step();
`endif
        check_sel("timing_adv", 2'd1);
        check_done("timing_adv", 1'b0);
        step();
        check_done("timing_pulse", 1'b1);
        step();
        check_done("timing_pulse_end", 1'b0);
        check_drain("timing");
    endtask

    task automatic test_reset_midrun();
        do_reset();
        send_runs(8, 'h200, 0);
        send_beat(BW'('h300), 2);
        send_beat(BW'('h301), 2);
        i_valid = 1'b1;
        i_data = BW'('h302);
        #3 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_leaf_write, o_leaf_data, o_leaf_sel, o_run_done} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs ready=%b write=%b data=%h sel=%0d done=%b expected all 0",
                     o_ready, o_leaf_write, o_leaf_data, o_leaf_sel, o_run_done);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_valid = 1'b0;
        check_sel("midrun_release", 2'd0);
        send_beat(BW'('h303), 0);
        i_valid = 1'b0;
        repeat (4) step();
        check_sel("midrun_after", 2'd0);
        check_drain("midrun");
    endtask

    initial begin
        i_rst_n = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_leaf_full = 4'b0000; i_data = '0;
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_flush();
        test_wrap();
        test_run_timing();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaf_feeder_p4.md
LEAF_FEEDER_P4 -- requirements
Module: leaf_feeder_p4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of one record; each beat carries two records (2*DATA_WIDTH bits).
REQ-002 SHALL have parameter RUN_LEN, default 16: beats per sorted run (power of two, 2..1024).
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data  input  2*DATA_WIDTH  incoming beat from the memory reader.
REQ-006 SHALL have port i_valid  input  1  i_data holds a beat.
REQ-007 SHALL have port o_ready  output  1  block accepts i_data this cycle.
REQ-008 SHALL have port i_flush  input  1  terminate the current partial run.
REQ-009 SHALL have port i_leaf_full  input  4  full flags of the four leaf FIFOs feeding the 4-leaf merger tree.
REQ-010 SHALL have port o_leaf_write  output  4  one-hot write enable per leaf FIFO.
REQ-011 SHALL have port o_leaf_data  output  2*DATA_WIDTH  shared write data to all leaf FIFOs.
REQ-012 SHALL have port o_leaf_sel  output  2  index of the leaf currently being filled.
REQ-013 SHALL have port o_run_done  output  1  one-cycle pulse after each run is closed.

Function
REQ-014 SHALL implement states STREAM and TERM; reset state STREAM.
REQ-015 SHALL drive o_ready = (state==STREAM) & ~i_leaf_full[sel] combinationally; a beat transfers when i_valid & o_ready.
REQ-016 SHALL, on transfer, assert o_leaf_write[sel] and drive o_leaf_data = i_data in the same cycle (zero latency); o_leaf_write SHALL be all-zero otherwise except in TERM.
REQ-017 SHALL keep beat counter beat_cnt (log2(RUN_LEN) bits), incremented per transfer, cleared when a run closes.
REQ-018 SHALL close a run when a transfer occurs with beat_cnt==RUN_LEN-1.
REQ-019 SHALL close a partial run when i_flush is high in STREAM with beat_cnt>0 and no transfer that cycle; i_flush with beat_cnt==0 SHALL be ignored; i_flush coincident with a transfer SHALL be ignored.
REQ-020 SHALL, in TERM, write an all-zero terminator beat to leaf sel when ~i_leaf_full[sel], then return to STREAM; while i_leaf_full[sel], SHALL hold TERM with o_leaf_write=0.
REQ-021 SHALL advance sel (3 wraps to 0) when a run finishes (terminator written, or run closed without terminator per REQ-027).
REQ-022 SHALL pulse o_run_done high for exactly one cycle, in the cycle after sel advances.
REQ-023 SHALL never write to a leaf whose i_leaf_full bit is high; full on other leaves SHALL not stall.

Reset
REQ-024 SHALL, while i_rst_n low, force state STREAM, sel=0, beat_cnt=0, o_run_done=0, o_leaf_write=0, o_ready=0, o_leaf_data=0.
REQ-025 SHALL, on reset mid-run, discard the partial run with no terminator; first beat after reset goes to leaf 0.

Configuration
REQ-026 SHALL, with macro LEAF_FEEDER_TERM_EN defined, implement TERM and terminator insertion per REQ-020.
REQ-027 SHALL, without LEAF_FEEDER_TERM_EN, omit TERM: a closing transfer or accepted flush advances sel in the same edge and pulses o_run_done next cycle; no zero beat is written.

Verification
REQ-028 SHALL cover, RUN_LEN=4, TERM_EN on, 8 back-to-back beats 1..8, no full -> leaf0 gets 1,2,3,4,0; leaf1 gets 5,6,7,8,0; two o_run_done pulses; sel ends at 2.
REQ-029 SHALL cover, TERM_EN on, i_leaf_full[0] held high on the cycle TERM is entered for 3 cycles -> o_ready=0, no write for 3 cycles, terminator written cycle 4, sel 0->1.
REQ-030 SHALL cover 2 beats then i_flush -> leaf0 gets A,B,0; next beat lands in leaf1 with beat_cnt restarting at 0; i_flush at beat_cnt 0 -> no write, sel unchanged.
REQ-031 SHALL cover 16 runs of RUN_LEN beats -> sel visits 0,1,2,3 four times and wraps 3->0; 16 o_run_done pulses.
REQ-032 SHALL cover i_rst_n low after 2 beats of a run on leaf2 -> all outputs 0 asynchronously; next beat after release goes to leaf0, no terminator emitted.
REQ-033 SHALL cover TERM_EN off, RUN_LEN=4, 4 beats -> leaf0 gets exactly 4 writes, sel=1 the cycle after the 4th, o_run_done one cycle later, no zero beat.
